multicycle_core: RTL and testbench

Multi-cycle successor to the single-cycle MIPS datapath. It runs the same instruction subset plus SUB/AND/OR/SLT over a single shared instruction/data memory port with a ready/valid-style handshake. Each instruction is sequenced through an FSM rather than completed in one cycle. The block sits between the memory subsystem and the top level and owns its PC, register file, ALU and control.

---
 rtl/mips_pkg.sv | 52 +++++
 rtl/mc_control.sv | 132 +++++++++++++
 rtl/multicycle_core.sv | 148 ++++++++++++++
 tb/tb_multicycle_core.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS subset definitions: opcodes, functs, ALU ops, FSM states.
// Also holds the 32-bit ALU evaluation helper.
package mips_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  function automatic logic [31:0] alu_f(
    input alu_op_e     op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] r;
    case (op)
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_SLT: r = {31'b0, $signed(a) < $signed(b)};
      default: r = a + b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_control.sv
// mc_control: next-state and datapath-enable decode for multicycle_core.
// In: state, opcode, funct, zero, misaligned, mem_ready, wd_expire. Out: state_d, enables/selects.
module mc_control
  import mips_pkg::*;
(
  input  state_e     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       misaligned,
  input  logic       mem_ready,
  input  logic       wd_expire,
  output state_e     state_d,
  output logic       ir_we,
  output logic       pc_inc,
  output logic       pc_jump,
  output logic       pc_branch,
  output logic       ab_we,
  output alu_op_e    alu_op,
  output logic       alu_imm,
  output logic       alu_out_we,
  output logic       mdr_we,
  output logic       rf_we,
  output logic       rf_dst_rd,
  output logic       rf_from_mdr,
  output logic       err_set
);

  logic is_r;
  logic is_mem;
  logic legal;

  always_comb begin
    is_r   = opcode == OP_R;
    is_mem = (opcode == OP_LW) || (opcode == OP_SW);
    if (is_r) begin
      legal = funct inside {FUNCT_ADD, FUNCT_SUB,
                            FUNCT_AND, FUNCT_OR, FUNCT_SLT};
    end else begin
      legal = opcode inside {OP_J, OP_BEQ, OP_ADDI,
                             OP_LW, OP_SW};
    end

    unique case (1'b1)
      opcode == OP_BEQ:           alu_op = ALU_SUB;
      is_r && funct == FUNCT_SUB: alu_op = ALU_SUB;
      is_r && funct == FUNCT_AND: alu_op = ALU_AND;
      is_r && funct == FUNCT_OR:  alu_op = ALU_OR;
      is_r && funct == FUNCT_SLT: alu_op = ALU_SLT;
      default:                    alu_op = ALU_ADD;
    endcase
    alu_imm = (opcode == OP_ADDI) || is_mem;

    state_d     = state;
    ir_we       = 1'b0;
    pc_inc      = 1'b0;
    pc_jump     = 1'b0;
    pc_branch   = 1'b0;
    ab_we       = 1'b0;
    alu_out_we  = 1'b0;
    mdr_we      = 1'b0;
    rf_we       = 1'b0;
    rf_dst_rd   = is_r;
    rf_from_mdr = opcode == OP_LW;
    err_set     = 1'b0;

    unique case (state)
      S_BOOT: state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end else if (wd_expire) begin
          err_set = 1'b1;
          state_d = S_HALT;
        end
      end
      S_DECODE: begin
        ab_we = 1'b1;
        if (!legal) begin
          state_d = S_HALT;
        end else if (opcode == OP_J) begin
          pc_jump = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (1'b1)
          opcode == OP_BEQ: begin
            pc_branch = zero;
            state_d   = S_FETCH;
          end
          is_mem: begin
            // Misaligned access halts before any request goes out.
            if (misaligned) begin
              state_d = S_HALT;
            end else begin
              alu_out_we = 1'b1;
              state_d    = S_MEM;
            end
          end
          default: begin
            alu_out_we = 1'b1;
            state_d    = S_WB;
          end
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (opcode == OP_SW) begin
            state_d = S_FETCH;
          end else begin
            mdr_we  = 1'b1;
            state_d = S_WB;
          end
        end else if (wd_expire) begin
          err_set = 1'b1;
          state_d = S_HALT;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
  end

endmodule

// File: rtl/multicycle_core.sv
// multicycle_core: FSM-sequenced MIPS subset core on one shared memory port.
// Ports: clk, rst (async low), mem_* handshake, halted, err_timeout, pc_dbg.
module multicycle_core
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic              err_timeout,
  output logic [ADDR_W-1:0] pc_dbg
);

  localparam logic [ADDR_W-1:0] JMASK =
    ADDR_W'(32'h0FFF_FFFF);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [31:0]       alu_out_q, alu_out_d;
  logic [31:0]       mdr_q, mdr_d;
  logic [31:0]       wait_q, wait_d;
  logic              err_q, err_d;
  logic [31:0]       rf_q [32];

  logic    ir_we, pc_inc, pc_jump, pc_branch;
  logic    ab_we, alu_imm, alu_out_we, mdr_we;
  logic    rf_we, rf_dst_rd, rf_from_mdr, err_set;
  alu_op_e alu_op;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, wr_idx;
  logic [31:0] simm, alu_b, alu_res, wr_data;
  logic        zero, misaligned, req, wd_expire;

  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign funct  = ir_q[5:0];
  assign simm   = {{16{ir_q[15]}}, ir_q[15:0]};

  assign alu_b      = alu_imm ? simm : b_q;
  assign alu_res    = alu_f(alu_op, a_q, alu_b);
  assign zero       = a_q == b_q;
  assign misaligned = |alu_res[1:0];
  assign req        = state_q inside {S_FETCH, S_MEM};

  // Fires on the last tolerated wait cycle so HALT lands on the next edge.
  assign wd_expire = (TIMEOUT != 0) && req && !mem_ready
                     && (wait_q == 32'(TIMEOUT - 1));

  assign wr_idx  = rf_dst_rd ? rd : rt;
  assign wr_data = rf_from_mdr ? mdr_q : alu_out_q;

  mc_control u_ctrl (
    .state       (state_q),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .misaligned  (misaligned),
    .mem_ready   (mem_ready),
    .wd_expire   (wd_expire),
    .state_d     (state_d),
    .ir_we       (ir_we),
    .pc_inc      (pc_inc),
    .pc_jump     (pc_jump),
    .pc_branch   (pc_branch),
    .ab_we       (ab_we),
    .alu_op      (alu_op),
    .alu_imm     (alu_imm),
    .alu_out_we  (alu_out_we),
    .mdr_we      (mdr_we),
    .rf_we       (rf_we),
    .rf_dst_rd   (rf_dst_rd),
    .rf_from_mdr (rf_from_mdr),
    .err_set     (err_set)
  );

  always_comb begin
    pc_d = pc_q;
    unique case (1'b1)
      pc_inc:    pc_d = pc_q + ADDR_W'(4);
      pc_jump:   pc_d = (pc_q & ~JMASK)
                        | ADDR_W'({ir_q[25:0], 2'b00});
      pc_branch: pc_d = pc_q
                        + ADDR_W'({simm[29:0], 2'b00});
      default:   pc_d = pc_q;
    endcase
    ir_d      = ir_we ? mem_rdata : ir_q;
    a_d       = ab_we ? rf_q[rs] : a_q;
    b_d       = ab_we ? rf_q[rt] : b_q;
    alu_out_d = alu_out_we ? alu_res : alu_out_q;
    mdr_d     = mdr_we ? mem_rdata : mdr_q;
    wait_d    = (req && !mem_ready) ? wait_q + 32'd1 : '0;
    err_d     = err_q | err_set;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_BOOT;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
      wait_q    <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      mdr_q     <= mdr_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
      if (rf_we && wr_idx != 5'd0) rf_q[wr_idx] <= wr_data;
    end
  end

  // Request outputs decode from state and held registers only.
  assign mem_req   = req;
  assign mem_we    = (state_q == S_MEM) && (opcode == OP_SW);
  assign mem_addr  = (state_q == S_FETCH) ? pc_q :
                     (state_q == S_MEM) ? alu_out_q[ADDR_W-1:0] :
                     '0;
  assign mem_wdata = (state_q == S_MEM) ? b_q : '0;

  assign halted      = state_q == S_HALT;
  assign err_timeout = err_q;
  assign pc_dbg      = pc_q;

endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: scoreboarded memory-port bench for multicycle_core.
// Expected requests are queued per program and popped as the core issues them.
module tb_multicycle_core;

  localparam logic [31:0] RPC = 32'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        halted, err_timeout;
  logic [31:0] pc_dbg;

  multicycle_core #(
    .ADDR_W   (32),
    .RESET_PC (RPC),
    .TIMEOUT  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .halted      (halted),
    .err_timeout (err_timeout),
    .pc_dbg      (pc_dbg)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic        f;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    int          gap;
  } txn_t;

  txn_t        sb[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] pa;
  int          errors = 0;
  int          checks = 0;
  int          extra = 0;
  int          cyc = 0;
  int          last_f = 0;
  int          rem = 0;
  bit          active = 0;
  bit          stall = 0;
  logic        cur_we;
  logic [31:0] cur_addr, cur_wd;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rr(input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic [4:0] rd,
                                     input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  task automatic emit(input logic [31:0] w);
    mem[pa] = w;
    pa += 32'd4;
  endtask

  task automatic exp_f(input logic [31:0] a, input int g);
    sb.push_back('{1'b1, 1'b0, a, 32'h0, g});
  endtask

  task automatic exp_ld(input logic [31:0] a);
    sb.push_back('{1'b0, 1'b0, a, 32'h0, 0});
  endtask

  task automatic exp_st(input logic [31:0] a,
                        input logic [31:0] d);
    sb.push_back('{1'b0, 1'b1, a, d, 0});
  endtask

  task automatic respond();
    if (stall) begin
      mem_ready = 1'b0;
    end else if (rem > 0) begin
      mem_ready = 1'b0;
      rem--;
    end else begin
      mem_ready = 1'b1;
      mem_rdata = rd_mem(cur_addr);
      if (cur_we) mem[cur_addr] = cur_wd;
      active = 0;
    end
  endtask

  // Memory responder: address 8 gets two wait states, all else zero.
  initial begin
    txn_t t;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst || !mem_req) begin
        active    = 0;
        mem_ready = !stall;
      end else if (!active) begin
        active   = 1;
        cur_we   = mem_we;
        cur_addr = mem_addr;
        cur_wd   = mem_wdata;
        rem      = (mem_addr == 32'h8) ? 2 : 0;
        if (sb.size() != 0) begin
          t = sb.pop_front();
          check("req_we", 32'(cur_we), 32'(t.we));
          check("req_addr", cur_addr, t.addr);
          if (t.we) check("req_wdata", cur_wd, t.wd);
          if (t.f) begin
            if (t.gap != 0) check("instr_cycles", cyc - last_f, t.gap);
            last_f = cyc;
          end
        end else begin
          extra++;
        end
        respond();
      end else begin
        check("hold_addr", mem_addr, cur_addr);
        check("hold_we", 32'(mem_we), 32'(cur_we));
        check("hold_wdata", mem_wdata, cur_wd);
        respond();
      end
    end
  end

  task automatic drain(input string tag);
    for (int i = 0; i < 500 && sb.size() != 0; i++) @(negedge clk);
    #1 check(tag, sb.size(), 0);
  endtask

  task automatic wait_halt();
    for (int i = 0; i < 50 && !halted; i++) @(negedge clk);
    #1;
  endtask

  task automatic enter_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    mem.delete();
    sb.delete();
    pa = RPC;
  endtask

  task automatic leave_reset();
    @(negedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench stalled");
  end

  initial begin
    bit found;
    int nreq;

    // Arithmetic, memory, branch and jump program.
    pa = RPC;
    emit(ri(6'h08, 5'd0, 5'd1, 16'd5));
    emit(ri(6'h08, 5'd0, 5'd2, 16'hFFFD));
    emit(rr(5'd1, 5'd2, 5'd3, 6'h20));
    emit(rr(5'd2, 5'd1, 5'd4, 6'h2A));
    emit(ri(6'h2B, 5'd0, 5'd3, 16'h0008));
    emit(ri(6'h23, 5'd0, 5'd5, 16'h0008));
    emit(rr(5'd1, 5'd2, 5'd6, 6'h22));
    emit(rr(5'd1, 5'd2, 5'd7, 6'h24));
    emit(rr(5'd1, 5'd2, 5'd8, 6'h25));
    emit(rr(5'd1, 5'd2, 5'd9, 6'h2A));
    emit(ri(6'h08, 5'd0, 5'd0, 16'd7));
    emit(ri(6'h2B, 5'd0, 5'd5, 16'h0300));
    emit(ri(6'h2B, 5'd0, 5'd4, 16'h0304));
    emit(ri(6'h2B, 5'd0, 5'd6, 16'h0308));
    emit(ri(6'h2B, 5'd0, 5'd7, 16'h030C));
    emit(ri(6'h2B, 5'd0, 5'd8, 16'h0310));
    emit(ri(6'h2B, 5'd0, 5'd9, 16'h0314));
    emit(ri(6'h2B, 5'd0, 5'd0, 16'h0318));
    emit(ri(6'h04, 5'd1, 5'd2, 16'd5));
    emit({6'h02, 26'd4});
    mem[32'h10] = ri(6'h04, 5'd1, 5'd1, 16'hFFFF);

    exp_f(32'h100, 0);
    exp_f(32'h104, 4);
    exp_f(32'h108, 4);
    exp_f(32'h10C, 4);
    exp_f(32'h110, 4);
    exp_st(32'h8, 32'h2);
    exp_f(32'h114, 6);
    exp_ld(32'h8);
    exp_f(32'h118, 7);
    exp_f(32'h11C, 4);
    exp_f(32'h120, 4);
    exp_f(32'h124, 4);
    exp_f(32'h128, 4);
    exp_f(32'h12C, 4);
    exp_st(32'h300, 32'h2);
    exp_f(32'h130, 4);
    exp_st(32'h304, 32'h1);
    exp_f(32'h134, 4);
    exp_st(32'h308, 32'h8);
    exp_f(32'h138, 4);
    exp_st(32'h30C, 32'h5);
    exp_f(32'h13C, 4);
    exp_st(32'h310, 32'hFFFF_FFFD);
    exp_f(32'h140, 4);
    exp_st(32'h314, 32'h0);
    exp_f(32'h144, 4);
    exp_st(32'h318, 32'h0);
    exp_f(32'h148, 4);
    exp_f(32'h14C, 3);
    exp_f(32'h10, 2);
    exp_f(32'h10, 3);
    exp_f(32'h10, 3);

    repeat (2) @(negedge clk);
    #1;
    check("rst_req", 32'(mem_req), 32'h0);
    check("rst_we", 32'(mem_we), 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_err", 32'(err_timeout), 32'h0);
    check("rst_pc", pc_dbg, RPC);

    leave_reset();
    @(negedge clk);
    #1;
    check("boot_req", 32'(mem_req), 32'h1);
    check("boot_addr", mem_addr, RPC);
    check("boot_we", 32'(mem_we), 32'h0);
    drain("prog_drain");
    check("mem8", rd_mem(32'h8), 32'h2);
    check("run_halted", 32'(halted), 32'h0);

    // Reset while a waited LW is pending, then illegal opcode.
    enter_reset();
    mem[32'h8]   = 32'h55;
    mem[32'h100] = ri(6'h23, 5'd0, 5'd1, 16'h0008);
    exp_f(32'h100, 0);
    exp_ld(32'h8);
    leave_reset();
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      #2;
      if (mem_req && !mem_we && mem_addr == 32'h8) found = 1;
    end
    check("lw_pending", 32'(found), 32'h1);
    rst = 1'b0;
    #1;
    check("abort_req", 32'(mem_req), 32'h0);
    check("abort_sb", sb.size(), 0);
    mem[32'h100] = ri(6'h2B, 5'd0, 5'd1, 16'h0320);
    mem[32'h104] = 32'hFC00_0000;
    exp_f(32'h100, 0);
    exp_st(32'h320, 32'h0);
    exp_f(32'h104, 4);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    drain("abort_drain");
    wait_halt();
    check("ill_halted", 32'(halted), 32'h1);
    check("ill_err", 32'(err_timeout), 32'h0);
    check("ill_req", 32'(mem_req), 32'h0);
    check("ill_pc", pc_dbg, 32'h108);

    // Misaligned load halts without a data request.
    enter_reset();
    mem[32'h100] = ri(6'h23, 5'd0, 5'd1, 16'h0002);
    exp_f(32'h100, 0);
    extra = 0;
    leave_reset();
    wait_halt();
    check("mis_halted", 32'(halted), 32'h1);
    check("mis_err", 32'(err_timeout), 32'h0);
    check("mis_extra", extra, 0);
    check("mis_pc", pc_dbg, 32'h104);

    // Watchdog with mem_ready held low.
    enter_reset();
    stall = 1;
    exp_f(32'h100, 0);
    leave_reset();
    nreq = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (halted) break;
      if (mem_req) nreq++;
    end
    check("to_reqs", nreq, 4);
    check("to_halted", 32'(halted), 32'h1);
    check("to_err", 32'(err_timeout), 32'h1);
    check("to_req", 32'(mem_req), 32'h0);
    check("to_pc", pc_dbg, RPC);
    stall = 0;
    repeat (3) @(negedge clk);
    #1;
    check("to_stay_req", 32'(mem_req), 32'h0);
    check("to_stay_halt", 32'(halted), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
